ssp_cfg_arbiter: RTL
====================

SSP_CFG_ARBITER -- requirements
Module: ssp_cfg_arbiter

Interface
REQ-001 Parameter ADDR_W, default 3: config register address width.
REQ-002 Parameter DATA_W, default 10: config register data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 a_req  input  1  requester A access request; level, held until a_ack.
REQ-006 a_rd_wr  input  1  requester A direction: 1 = read, 0 = write.
REQ-007 a_addr  input  ADDR_W  requester A register address.
REQ-008 a_wdata  input  DATA_W  requester A write data.
REQ-009 a_ack  output  1  one-cycle completion pulse to requester A.
REQ-010 b_req, b_rd_wr, b_addr, b_wdata, b_ack SHALL mirror REQ-005..REQ-009 for requester B.
REQ-011 rdata  output  DATA_W  read data for the completing access; valid only in the ack cycle.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 cfg_enable  output  1  ssp_uart config enable.
REQ-014 cfg_rd_wr  output  1  ssp_uart config direction.
REQ-015 cfg_addr  output  ADDR_W  ssp_uart config address.
REQ-016 cfg_wdata  output  DATA_W  ssp_uart config write data.
REQ-017 cfg_rdata  input  DATA_W  ssp_uart config read data.

Function
REQ-018 FSM states SHALL be IDLE, ACC1, ACC2, RESP; all outputs registered.
REQ-019 IDLE: with any req high at the edge -> pick the winner, latch its rd_wr/addr/wdata onto the cfg_* registers, set cfg_enable=1, go to ACC1; otherwise stay in IDLE.
REQ-020 ACC1 -> ACC2 unconditionally; cfg_enable stays 1 for exactly two cycles (ACC1, ACC2).
REQ-021 ACC2 -> RESP: clear cfg_enable; if the access is a read, capture cfg_rdata into rdata at this edge.
REQ-022 RESP: pulse the winner's ack for one cycle, hold rdata, then go to IDLE; the loser's ack stays 0.
REQ-023 Latency: req sampled at edge N -> cfg_enable high in cycles N+1..N+2 -> ack in cycle N+3; back-to-back throughput is one access per 4 cycles.
REQ-024 cfg_rd_wr, cfg_addr and cfg_wdata SHALL stay stable from ACC1 through RESP; changes to requester inputs after the grant are ignored.
REQ-025 Default arbitration is round-robin on a 1-bit last_grant pointer, updated on entry to ACC1.
- Single request: granted regardless of pointer.
- Simultaneous requests: the requester not equal to last_grant wins.
REQ-026 A req still high in the cycle after its ack is treated as a new request.
REQ-027 For writes, rdata SHALL be 0 in the ack cycle.
REQ-028 rdata SHALL retain its last value outside RESP; it is not cleared.

Reset
REQ-029 rst low SHALL immediately force: state=IDLE, cfg_enable=0, cfg_rd_wr=0, cfg_addr=0, cfg_wdata=0, a_ack=0, b_ack=0, rdata=0, busy=0, last_grant=B (so A wins the first tie).
REQ-030 Reset during ACC1/ACC2/RESP SHALL abort the access with no ack; after release, the arbiter re-arbitrates from IDLE.

Configuration
REQ-031 Macro SSP_CFG_ARB_FIXED_PRIO_EN defined: fixed priority, A always beats B on simultaneous requests; last_grant is unused.
REQ-032 Macro SSP_CFG_ARB_FIXED_PRIO_EN undefined: round-robin per REQ-025.

Verification
REQ-033 A write addr=0, wdata=1 alone -> cfg_enable=1 for 2 cycles with cfg_addr=0, cfg_wdata=1, cfg_rd_wr=0; a_ack in cycle N+3; b_ack never asserted.
REQ-034 B read addr=3 with cfg_rdata=10'h155 -> rdata=10'h155 and b_ack in the same cycle, 3 cycles after the request edge.
REQ-035 A and B request together out of reset, both held (round-robin build) -> grant order A, B, A, B; acks spaced 4 cycles apart.
REQ-036 Same stimulus with SSP_CFG_ARB_FIXED_PRIO_EN defined -> A granted on every arbitration while a_req is held; B starved.
REQ-037 rst driven low in ACC2 -> cfg_enable=0 asynchronously, no ack; after release, a pending B request is granted first if A is idle.
REQ-038 A changes a_addr from 0 to 3 during ACC1 -> cfg_addr stays 0 through RESP.

Source files
------------

// File: rtl/ssp_cfg_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : ssp_cfg_arbiter_if
//  Brief    : Bus bundle between two config requesters, the arbiter and the
//             ssp_uart configuration port.
//  Revision : 1.0 - initial release
// ============================================================================
interface ssp_cfg_arbiter_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 10
);
  // requester A
  logic              a_req;
  logic              a_rd_wr;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_ack;
  // requester B
  logic              b_req;
  logic              b_rd_wr;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_ack;
  // shared response / status
  logic [DATA_W-1:0] rdata;
  logic              busy;
  // ssp_uart config port
  logic              cfg_enable;
  logic              cfg_rd_wr;
  logic [ADDR_W-1:0] cfg_addr;
  logic [DATA_W-1:0] cfg_wdata;
  logic [DATA_W-1:0] cfg_rdata;

  // arbiter view
  modport slave (
    input  a_req, a_rd_wr, a_addr, a_wdata,
    input  b_req, b_rd_wr, b_addr, b_wdata,
    input  cfg_rdata,
    output a_ack, b_ack, rdata, busy,
    output cfg_enable, cfg_rd_wr, cfg_addr, cfg_wdata
  );

  // requester / uart side view
  modport master (
    output a_req, a_rd_wr, a_addr, a_wdata,
    output b_req, b_rd_wr, b_addr, b_wdata,
    output cfg_rdata,
    input  a_ack, b_ack, rdata, busy,
    input  cfg_enable, cfg_rd_wr, cfg_addr, cfg_wdata
  );
endinterface
`default_nettype wire

// File: rtl/ssp_cfg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ssp_cfg_arbiter
//  Brief    : Two-requester arbiter for the ssp_uart configuration port.
//             Each access holds cfg_enable for two cycles, then acks the
//             winner one cycle later. Round-robin on a 1-bit last-grant
//             pointer by default; defining SSP_CFG_ARB_FIXED_PRIO_EN gives
//             requester A fixed priority instead.
//  Revision : 1.0 - initial release
// ============================================================================
module ssp_cfg_arbiter #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 10
) (
  input  wire logic         clk,
  input  wire logic         rst,   // asynchronous, active-low
  ssp_cfg_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC1 = 2'd1,
    ACC2 = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  // grant owner of the access in flight: 0 = A, 1 = B
  logic              r_grant;
  logic              w_grant_nxt;

  logic              r_cfg_enable, w_cfg_enable_nxt;
  logic              r_cfg_rd_wr,  w_cfg_rd_wr_nxt;
  logic [ADDR_W-1:0] r_cfg_addr,   w_cfg_addr_nxt;
  logic [DATA_W-1:0] r_cfg_wdata,  w_cfg_wdata_nxt;
  logic              r_a_ack,      w_a_ack_nxt;
  logic              r_b_ack,      w_b_ack_nxt;
  logic [DATA_W-1:0] r_rdata,      w_rdata_nxt;
  logic              r_busy,       w_busy_nxt;

  logic              w_a_wins;

`ifdef SSP_CFG_ARB_FIXED_PRIO_EN
  // A beats B whenever it is requesting
  assign w_a_wins = bus.a_req;
`else
  // 0 = A was granted last, 1 = B was granted last
  logic              r_last_grant, w_last_grant_nxt;
  // A wins when alone, or on a tie when B had the previous grant
  assign w_a_wins = bus.a_req & (~bus.b_req | r_last_grant);
`endif

  // next-state and next-output computation
  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_cfg_enable_nxt = r_cfg_enable;
    w_cfg_rd_wr_nxt  = r_cfg_rd_wr;
    w_cfg_addr_nxt   = r_cfg_addr;
    w_cfg_wdata_nxt  = r_cfg_wdata;
    w_a_ack_nxt      = 1'b0;
    w_b_ack_nxt      = 1'b0;
    w_rdata_nxt      = r_rdata;
`ifndef SSP_CFG_ARB_FIXED_PRIO_EN
    w_last_grant_nxt = r_last_grant;
`endif
    case (r_state)
      IDLE: begin
        if (bus.a_req || bus.b_req) begin
          w_state_nxt      = ACC1;
          w_grant_nxt      = ~w_a_wins;
          w_cfg_enable_nxt = 1'b1;
          w_cfg_rd_wr_nxt  = w_a_wins ? bus.a_rd_wr : bus.b_rd_wr;
          w_cfg_addr_nxt   = w_a_wins ? bus.a_addr  : bus.b_addr;
          w_cfg_wdata_nxt  = w_a_wins ? bus.a_wdata : bus.b_wdata;
`ifndef SSP_CFG_ARB_FIXED_PRIO_EN
          w_last_grant_nxt = ~w_a_wins;
`endif
        end
      end
      ACC1: begin
        w_state_nxt = ACC2;
      end
      ACC2: begin
        // writes return zero so stale read data never leaks into a write ack
        w_state_nxt      = RESP;
        w_cfg_enable_nxt = 1'b0;
        w_rdata_nxt      = r_cfg_rd_wr ? bus.cfg_rdata : '0;
        w_a_ack_nxt      = ~r_grant;
        w_b_ack_nxt      = r_grant;
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt != IDLE);
  end

  // state and registered outputs; reset aborts any access in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_grant      <= 1'b0;
      r_cfg_enable <= 1'b0;
      r_cfg_rd_wr  <= 1'b0;
      r_cfg_addr   <= '0;
      r_cfg_wdata  <= '0;
      r_a_ack      <= 1'b0;
      r_b_ack      <= 1'b0;
      r_rdata      <= '0;
      r_busy       <= 1'b0;
`ifndef SSP_CFG_ARB_FIXED_PRIO_EN
      r_last_grant <= 1'b1;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_cfg_enable <= w_cfg_enable_nxt;
      r_cfg_rd_wr  <= w_cfg_rd_wr_nxt;
      r_cfg_addr   <= w_cfg_addr_nxt;
      r_cfg_wdata  <= w_cfg_wdata_nxt;
      r_a_ack      <= w_a_ack_nxt;
      r_b_ack      <= w_b_ack_nxt;
      r_rdata      <= w_rdata_nxt;
      r_busy       <= w_busy_nxt;
`ifndef SSP_CFG_ARB_FIXED_PRIO_EN
      r_last_grant <= w_last_grant_nxt;
`endif
    end
  end

  assign bus.cfg_enable = r_cfg_enable;
  assign bus.cfg_rd_wr  = r_cfg_rd_wr;
  assign bus.cfg_addr   = r_cfg_addr;
  assign bus.cfg_wdata  = r_cfg_wdata;
  assign bus.a_ack      = r_a_ack;
  assign bus.b_ack      = r_b_ack;
  assign bus.rdata      = r_rdata;
  assign bus.busy       = r_busy;

endmodule
`default_nettype wire
